// File: rtl/pac_dir_queue_pkg.sv
// Shared types for the pac input-conditioning path: direction encoding,
// W/A/S/D keycodes and the opposite-direction helper.
package pac_pkg;

  typedef enum logic [2:0] {
    DIR_NONE  = 3'd0,
    DIR_UP    = 3'd1,
    DIR_DOWN  = 3'd2,
    DIR_LEFT  = 3'd3,
    DIR_RIGHT = 3'd4
  } dir_t;

  typedef enum logic {
    ST_EMPTY,
    ST_PENDING
  } state_t;

  localparam logic [15:0] KEY_W = 16'h001A;
  localparam logic [15:0] KEY_A = 16'h0004;
  localparam logic [15:0] KEY_S = 16'h0016;
  localparam logic [15:0] KEY_D = 16'h0007;

  function automatic dir_t opposite(input dir_t d);
    case (d)
      DIR_UP:    opposite = DIR_DOWN;
      DIR_DOWN:  opposite = DIR_UP;
      DIR_LEFT:  opposite = DIR_RIGHT;
      DIR_RIGHT: opposite = DIR_LEFT;
      default:   opposite = DIR_NONE;
    endcase
  endfunction

endpackage

// File: rtl/pac_dir_queue_if.sv
// Bus between the keyboard/motion side and the direction queue.
interface pac_dir_queue_if;
  import pac_pkg::*;

  logic [15:0] keycode;
  logic [9:0]  pac_x;
  logic [9:0]  pac_y;
  dir_t        dir_cur;
  dir_t        dir_pend;
  logic [9:0]  step_x;
  logic [9:0]  step_y;
  logic        turn_pulse;

  modport master (
    output keycode, pac_x, pac_y,
    input  dir_cur, dir_pend, step_x, step_y, turn_pulse
  );

  modport slave (
    input  keycode, pac_x, pac_y,
    output dir_cur, dir_pend, step_x, step_y, turn_pulse
  );
endinterface

// File: rtl/pac_dir_queue_key_decode.sv
// Raw 16-bit keycode to direction; anything other than W/A/S/D is no key.
module key_decode
  import pac_pkg::*;
(
  input  logic [15:0] keycode,
  output dir_t        dir
);
  always_comb begin
    case (keycode)
      KEY_W:   dir = DIR_UP;
      KEY_S:   dir = DIR_DOWN;
      KEY_A:   dir = DIR_LEFT;
      KEY_D:   dir = DIR_RIGHT;
      default: dir = DIR_NONE;
    endcase
  end
endmodule

// File: rtl/pac_dir_queue.sv
// Buffers the latest W/A/S/D press and commits it when pac is tile-aligned,
// reversing, or stopped; drives the committed direction and per-axis steps.
module pac_dir_queue
  import pac_pkg::*;
#(
  parameter int TILE_LOG2   = 3,
  parameter int ALIGN_OFS   = 4,
  parameter int HOLD_FRAMES = 16,
  parameter int STEP        = 1
) (
  input  logic             frame_clk,
  input  logic             Reset_n,
  pac_dir_queue_if.slave   bus
);

  localparam logic [TILE_LOG2-1:0] ALIGN_V   = TILE_LOG2'(ALIGN_OFS);
  localparam logic [7:0]           HOLD_LAST = 8'(HOLD_FRAMES - 1);
  localparam logic [9:0]           STEP_P    = 10'(STEP);
  localparam logic [9:0]           STEP_N    = ~STEP_P + 10'd1;

  state_t     state;
  dir_t       dir_cur;
  dir_t       dir_pend;
  logic [7:0] timer;
  logic       turn_pulse;
  logic [9:0] step_x;
  logic [9:0] step_y;

  dir_t       key;
  logic       aligned;
  logic       commit;
  dir_t       dir_nxt;
  logic [9:0] step_x_nxt;
  logic [9:0] step_y_nxt;

  key_decode u_key_decode (
    .keycode (bus.keycode),
    .dir     (key)
  );

  assign aligned = (bus.pac_x[TILE_LOG2-1:0] == ALIGN_V) &&
                   (bus.pac_y[TILE_LOG2-1:0] == ALIGN_V);

  // Commit only ever happens out of PENDING; steps track the post-edge direction.
  assign commit  = (state == ST_PENDING) &&
                   (aligned || (dir_pend == opposite(dir_cur)) || (dir_cur == DIR_NONE));
  assign dir_nxt = commit ? dir_pend : dir_cur;

  always_comb begin
    step_x_nxt = '0;
    step_y_nxt = '0;
    case (dir_nxt)
      DIR_UP:    step_y_nxt = STEP_N;
      DIR_DOWN:  step_y_nxt = STEP_P;
      DIR_LEFT:  step_x_nxt = STEP_N;
      DIR_RIGHT: step_x_nxt = STEP_P;
      default:   ;
    endcase
  end

  always_ff @(posedge frame_clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state      <= ST_EMPTY;
      dir_cur    <= DIR_NONE;
      dir_pend   <= DIR_NONE;
      timer      <= '0;
      turn_pulse <= 1'b0;
      step_x     <= '0;
      step_y     <= '0;
    end else begin
      turn_pulse <= 1'b0;
      step_x     <= step_x_nxt;
      step_y     <= step_y_nxt;
      case (state)
        ST_EMPTY: begin
          if (key != DIR_NONE && key != dir_cur) begin
            dir_pend <= key;
            timer    <= '0;
            state    <= ST_PENDING;
          end
        end
        ST_PENDING: begin
          if (commit) begin
            dir_cur    <= dir_pend;
            turn_pulse <= (dir_pend != dir_cur);
            // A different key on the commit edge becomes the next pending turn.
            if (key != DIR_NONE && key != dir_pend) begin
              dir_pend <= key;
              timer    <= '0;
            end else begin
              dir_pend <= DIR_NONE;
              state    <= ST_EMPTY;
            end
          end else if (key != DIR_NONE) begin
            dir_pend <= key;
            timer    <= '0;
          end else if (timer == HOLD_LAST) begin
            dir_pend <= DIR_NONE;
            state    <= ST_EMPTY;
          end else begin
            timer <= timer + 8'd1;
          end
        end
        default: state <= ST_EMPTY;
      endcase
    end
  end

  assign bus.dir_cur    = dir_cur;
  assign bus.dir_pend   = dir_pend;
  assign bus.step_x     = step_x;
  assign bus.step_y     = step_y;
  assign bus.turn_pulse = turn_pulse;

  // Only the in-tile offset bits of the position matter here.
  logic unused_pos;
  assign unused_pos = ^{bus.pac_x[9:TILE_LOG2], bus.pac_y[9:TILE_LOG2]};

endmodule

// File: tb/tb_pac_dir_queue.sv
// Directed bench for pac_dir_queue: reset, start, expiry, reversal, overwrite,
// aligned turn and commit-edge key handling.
module tb_pac_dir_queue;
  import pac_pkg::*;

  logic frame_clk;
  logic Reset_n;
  int   checks;
  int   errors;

  pac_dir_queue_if bus ();

  pac_dir_queue #(
    .TILE_LOG2   (3),
    .ALIGN_OFS   (4),
    .HOLD_FRAMES (16),
    .STEP        (1)
  ) dut (
    .frame_clk (frame_clk),
    .Reset_n   (Reset_n),
    .bus       (bus.slave)
  );

  initial frame_clk = 1'b0;
  always #5 frame_clk = ~frame_clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge frame_clk);
    #1;
  endtask

  task automatic check_all(input string tag, input logic [2:0] cur, input logic [2:0] pend,
                           input logic [9:0] sx, input logic [9:0] sy, input logic tp);
    check({tag, ".dir_cur"},    16'(bus.dir_cur),    16'(cur));
    check({tag, ".dir_pend"},   16'(bus.dir_pend),   16'(pend));
    check({tag, ".step_x"},     16'(bus.step_x),     16'(sx));
    check({tag, ".step_y"},     16'(bus.step_y),     16'(sy));
    check({tag, ".turn_pulse"}, 16'(bus.turn_pulse), 16'(tp));
  endtask

  initial begin
    checks = 0;
    errors = 0;
    bus.keycode = 16'h0000;
    bus.pac_x   = 10'd101;
    bus.pac_y   = 10'd21;
    Reset_n     = 1'b1;

    // Asynchronous reset between edges
    #2 Reset_n = 1'b0;
    #1 check_all("rst_async", 3'd0, 3'd0, 10'h000, 10'h000, 1'b0);
    tick();
    tick();
    Reset_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("idle.dir_cur", 16'(bus.dir_cur), 16'd0);
      check("idle.step_x",  16'(bus.step_x),  16'd0);
    end

    // Start from stop: RIGHT
    bus.keycode = 16'h0007;
    tick();
    check_all("start_load", 3'd0, 3'd4, 10'h000, 10'h000, 1'b0);
    bus.keycode = 16'h0000;
    tick();
    check_all("start_commit", 3'd4, 3'd0, 10'h001, 10'h000, 1'b1);
    tick();
    check("start_pulse_clr", 16'(bus.turn_pulse), 16'd0);

    // Expiry: DOWN pressed once, never aligned (pac_y=21)
    bus.keycode = 16'h0016;
    tick();
    check("exp_load", 16'(bus.dir_pend), 16'd2);
    bus.keycode = 16'h0000;
    for (int i = 0; i < 15; i++) begin
      tick();
      check("exp_hold.dir_pend", 16'(bus.dir_pend), 16'd2);
      check("exp_hold.pulse",    16'(bus.turn_pulse), 16'd0);
    end
    tick();
    check_all("exp_drop", 3'd4, 3'd0, 10'h001, 10'h000, 1'b0);

    // Reversal RIGHT -> LEFT while unaligned
    bus.keycode = 16'h0004;
    tick();
    check_all("rev_load", 3'd4, 3'd3, 10'h001, 10'h000, 1'b0);
    bus.keycode = 16'h0000;
    tick();
    check_all("rev_commit", 3'd3, 3'd0, 10'h3FF, 10'h000, 1'b1);
    bus.keycode = 16'h0007;
    tick();
    bus.keycode = 16'h0000;
    tick();
    check_all("rev_back", 3'd4, 3'd0, 10'h001, 10'h000, 1'b1);

    // Overwrite UP with DOWN, then hold DOWN for 40 frames
    bus.keycode = 16'h001A;
    tick();
    check("ovr_up", 16'(bus.dir_pend), 16'd1);
    bus.keycode = 16'h0000;
    tick();
    tick();
    bus.keycode = 16'h0016;
    tick();
    check("ovr_down", 16'(bus.dir_pend), 16'd2);
    for (int i = 0; i < 40; i++) begin
      tick();
      check("hold.dir_pend", 16'(bus.dir_pend), 16'd2);
      check("hold.dir_cur",  16'(bus.dir_cur),  16'd4);
    end
    bus.keycode = 16'h0000;
    for (int i = 0; i < 15; i++) tick();
    check("hold_rel_last", 16'(bus.dir_pend), 16'd2);
    tick();
    check("hold_rel_drop", 16'(bus.dir_pend), 16'd0);

    // Aligned turn: UP pressed at x=97, commit when x=100
    bus.pac_y   = 10'd20;
    bus.pac_x   = 10'd97;
    bus.keycode = 16'h001A;
    tick();
    check("al_load", 16'(bus.dir_pend), 16'd1);
    bus.keycode = 16'h0000;
    bus.pac_x   = 10'd98;
    tick();
    check_all("al_x98", 3'd4, 3'd1, 10'h001, 10'h000, 1'b0);
    bus.pac_x = 10'd99;
    tick();
    check_all("al_x99", 3'd4, 3'd1, 10'h001, 10'h000, 1'b0);
    bus.pac_x = 10'd100;
    tick();
    check_all("al_x100", 3'd1, 3'd0, 10'h000, 10'h3FF, 1'b1);

    // Key equal to current direction is ignored
    bus.keycode = 16'h001A;
    tick();
    check_all("same_dir", 3'd1, 3'd0, 10'h000, 10'h3FF, 1'b0);

    // Held key on its own commit edge is discarded
    bus.keycode = 16'h0004;
    tick();
    check("held_load", 16'(bus.dir_pend), 16'd3);
    tick();
    check_all("held_commit", 3'd3, 3'd0, 10'h3FF, 10'h000, 1'b1);
    tick();
    check_all("held_after", 3'd3, 3'd0, 10'h3FF, 10'h000, 1'b0);

    // New key on a commit edge becomes the next pending turn
    bus.keycode = 16'h001A;
    tick();
    bus.keycode = 16'h0016;
    tick();
    check_all("chain_commit", 3'd1, 3'd2, 10'h000, 10'h3FF, 1'b1);
    bus.keycode = 16'h0000;
    tick();
    check_all("chain_rev", 3'd2, 3'd0, 10'h000, 10'h001, 1'b1);

    // Asynchronous reset mid-run with state live
    #2 Reset_n = 1'b0;
    #1 check_all("rst_mid", 3'd0, 3'd0, 10'h000, 10'h000, 1'b0);
    tick();
    Reset_n = 1'b1;
    tick();
    check("rst_mid_after", 16'(bus.dir_cur), 16'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pac_dir_queue.md
Name: pac_dir_queue

Overview:
- Input-conditioning stage directly upstream of the pac motion block.
- Samples the raw USB keycode once per frame and buffers the most recent W/A/S/D press as a pending turn.
- Commits the pending turn only when pac is tile-aligned, when the turn is an immediate reversal, or when pac is stopped.
- Drives a clean current direction plus signed per-axis step values that the motion block adds to pac position.

Parameters:
- TILE_LOG2, 3, log2 of maze tile size in pixels (tile = 8 px).
- ALIGN_OFS, 4, pixel offset within a tile where pac centre is aligned (0..2^TILE_LOG2-1).
- HOLD_FRAMES, 16, frames a pending turn survives without commit before it is dropped (1..255).
- STEP, 1, pixels per frame moved along the active axis.

Ports:
- frame_clk  in  1  frame-rate clock (one rising edge per VGA frame).
- Reset_n  in  1  asynchronous, active-low reset.
- keycode  in  16  raw keycode from the keyboard interface.
- pac_x  in  10  current pac X position (feedback from motion block).
- pac_y  in  10  current pac Y position.
- dir_cur  out  3  committed direction: 0 NONE, 1 UP, 2 DOWN, 3 LEFT, 4 RIGHT.
- dir_pend  out  3  pending direction, same encoding; 0 when empty.
- step_x  out  10  two's-complement X step for this frame.
- step_y  out  10  two's-complement Y step for this frame.
- turn_pulse  out  1  high for exactly one frame after a commit that changed dir_cur.

Behaviour:
- Reset, asynchronous while Reset_n=0: dir_cur=NONE, dir_pend=NONE, hold timer=0, turn_pulse=0, step_x=step_y=0, FSM=EMPTY. Release takes effect at the next frame_clk edge.
- Keycode decode, combinational:
  - 0x001A → UP, 0x0016 → DOWN, 0x0004 → LEFT, 0x0007 → RIGHT.
  - Any other value, including 0x0000, is "no key".
- aligned = (pac_x[TILE_LOG2-1:0]==ALIGN_OFS) && (pac_y[TILE_LOG2-1:0]==ALIGN_OFS).
- reverse(p) = p is the opposite of dir_cur (UP↔DOWN, LEFT↔RIGHT).
- FSM states: EMPTY, PENDING. All evaluation is on the rising edge of frame_clk, using registered values.
- EMPTY:
  - Decoded key k≠none and k≠dir_cur: dir_pend<=k, timer<=0, go to PENDING.
  - k==dir_cur: ignored.
- PENDING, commit check. Commit condition = aligned OR reverse(dir_pend) OR dir_cur==NONE.
  - Condition true: dir_cur<=dir_pend, turn_pulse<=1, go to EMPTY.
  - Condition false and timer==HOLD_FRAMES-1: drop the pending turn, dir_pend<=NONE, go to EMPTY, no pulse.
  - Otherwise: timer<=timer+1.
- PENDING, same edge as the commit check, a new valid key k arrives:
  - k≠dir_pend: dir_pend<=k, timer<=0 (last press wins). This holds even on a commit edge: the old pending commits and k is loaded, so the state stays PENDING.
  - k==dir_pend (key held): timer<=0.
  - A loaded k equal to the newly committed dir_cur is discarded, and the state goes to EMPTY.
- turn_pulse is cleared on every edge that does not commit.
- Step generation is registered and reflects dir_cur on the same edge that dir_cur updates:
  - UP: step_y = -STEP, step_x = 0.
  - DOWN: step_y = +STEP, step_x = 0.
  - LEFT: step_x = -STEP, step_y = 0.
  - RIGHT: step_x = +STEP, step_y = 0.
  - NONE: both 0.
  - Negatives are 10-bit two's complement, so STEP=1 gives 0x3FF.
- Latency: key to dir_cur is at least 2 edges (load, then commit). Commit to step change is 0 additional edges.
- The timer is 8 bits and never wraps, because it is capped by HOLD_FRAMES-1.
- No wall or screen-edge logic here; bounce remains the motion block's responsibility.

Decomposition:
- Shared package pac_pkg holds:
  - dir_t enum (NONE, UP, DOWN, LEFT, RIGHT; 3-bit).
  - Keycode constants KEY_W/A/S/D.
  - Function opposite(dir_t).
- Sub-module key_decode: combinational 16-bit keycode → dir_t. It is reused later by the ghost-debug and menu logic.
- The FSM, timer and step registers stay in pac_dir_queue.

Test Plan:
- Reset release: Reset_n low at arbitrary time → all outputs 0 immediately. After release with keycode=0 for 5 frames, dir_cur stays NONE and steps stay 0.
- Start from stop: dir_cur=NONE, keycode=0x0007 one frame → dir_pend=RIGHT at edge 1. At edge 2: dir_cur=RIGHT, step_x=0x001, turn_pulse=1 for one frame.
- Reversal: dir_cur=RIGHT, pac_x=101 (unaligned), keycode=0x0004 → dir_cur=LEFT one edge after load, step_x=0x3FF.
- Aligned turn: dir_cur=RIGHT, pac_y=20, keycode=0x001A pulsed once at pac_x=97 → no commit while pac_x=97..99. Commit on the edge where pac_x=100 (100[2:0]=4), then step_y=0x3FF, step_x=0.
- Expiry: dir_cur=RIGHT, pac_y=21 (never aligned), keycode=0x0016 for one frame then 0 → dir_pend=DOWN for 16 frames, then NONE. dir_cur stays RIGHT, no turn_pulse.
- Overwrite and hold: pending UP (unaligned) and keycode switches to 0x0016 → dir_pend=DOWN, timer reset. Holding 0x0016 for 40 unaligned frames keeps dir_pend=DOWN with no expiry.
